// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared UART state encoding and framing constants for the serial front-end
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_t;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - circular byte FIFO with registered full flag and occupancy count
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_n;
  logic             do_push;
  logic             do_pop;

  // full is a flop, so a pop in the same cycle never rescues a push into a full FIFO
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_n = count;
    if (do_push && !do_pop)
      count_n = count + 1'b1;
    else if (!do_push && do_pop)
      count_n = count - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_n;
      full  <= (count_n == FULL_COUNT);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered 8N1 UART transmitter: byte FIFO feeding a start/data/stop serialiser
module uart_tx_fifo
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [UART_DATA_BITS-1:0]     tx_data,
  input  logic                          tx_enable,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(UART_DATA_BITS - 1);

  uart_state_t               state, state_n;
  logic [CW-1:0]             cnt, cnt_n;
  logic [IW-1:0]             idx, idx_n;
  logic [UART_DATA_BITS-1:0] shift, shift_n;
  logic [UART_DATA_BITS-1:0] pop_data;
  logic                      pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      tx_n;
  logic                      baud_last;

  byte_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_enable),
    .push_data (tx_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign tx_ready  = !fifo_full;
  assign tx_busy   = (state != IDLE) || !fifo_empty;
  assign baud_last = (cnt == BAUD_LAST);

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    shift_n = shift;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = pop_data;
          state_n = START;
        end
      end
      START: begin
        if (baud_last) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (baud_last) begin
          cnt_n   = '0;
          shift_n = shift >> 1;
          if (idx == IDX_LAST)
            state_n = STOP;
          else
            idx_n = idx + 1'b1;
        end
      end
      STOP: begin
        // chaining straight into START keeps queued bytes gap-free on the line
        if (baud_last) begin
          cnt_n = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_n = pop_data;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // line level is decided from the next state so tx can come straight off a flop
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
      tx    <= tx_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo against a frame-level reference model
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_enable = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic [3:0] fifo_count;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .tx_data    (tx_data),
    .tx_enable  (tx_enable),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus "cycles left in the frame on the line".
  logic [7:0] m_fifo[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_byte = 8'h00;
  int         frame_rem = 0;
  bit         m_ready = 1'b1;
  bit         m_push;
  bit         m_pop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fifo.delete();
      exp_q.delete();
      frame_rem = 0;
      m_ready   = 1'b1;
    end else begin
      m_push = tx_enable && m_ready;
      m_pop  = (m_fifo.size() > 0) && (frame_rem <= 1);
      if (m_pop) begin
        m_byte    = m_fifo.pop_front();
        frame_rem = FRAME;
      end else if (frame_rem > 0) begin
        frame_rem--;
      end
      if (m_push) begin
        m_fifo.push_back(tx_data);
        exp_q.push_back(tx_data);
      end
      m_ready = (m_fifo.size() != DEPTH);
    end
  end

  function automatic logic exp_tx();
    int pos;
    int b;
    if (frame_rem == 0) return 1'b1;
    pos = FRAME - frame_rem;
    b   = pos / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_byte[b-1];
  endfunction

  always @(negedge clk) begin
    chk("tx_line", tx, exp_tx());
    chk("fifo_count", fifo_count, m_fifo.size());
    chk("tx_ready", tx_ready, m_ready);
    chk("tx_busy", tx_busy, (frame_rem > 0) || (m_fifo.size() > 0));
  end

  // Line monitor: decodes frames mid-bit and pops the scoreboard per frame.
  bit         mon_active = 1'b0;
  int         mon_t = 0;
  logic [7:0] mon_byte = 8'h00;
  logic [7:0] exp_byte;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx == 1'b0) begin
        mon_active = 1'b1;
        mon_t      = 0;
      end
    end else begin
      mon_t++;
    end
    if (mon_active && (mon_t % CPB) == CPB / 2) begin
      if (mon_t / CPB == 0) begin
        chk("start_bit", tx, 1'b0);
      end else if (mon_t / CPB <= 8) begin
        mon_byte[mon_t / CPB - 1] = tx;
      end else begin
        chk("stop_bit", tx, 1'b1);
        chk("frame_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          exp_byte = exp_q.pop_front();
          chk("frame_byte", mon_byte, exp_byte);
        end
        mon_active = 1'b0;
      end
    end
  end

  task automatic wr(input logic [7:0] d);
    @(negedge clk);
    tx_enable = 1'b1;
    tx_data   = d;
  endtask

  task automatic stop_wr();
    @(negedge clk);
    tx_enable = 1'b0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (m_fifo.size() == 0 && frame_rem == 0 && !mon_active) break;
    end
    chk("drain_in_time", i < 5000, 1'b1);
  endtask

  initial begin
    int idx;
    int guard;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_tx", tx, 1'b1);
    chk("reset_ready", tx_ready, 1'b1);
    chk("reset_busy", tx_busy, 1'b0);
    chk("reset_count", fifo_count, 4'd0);

    wr(8'hA5);
    stop_wr();
    drain();

    wr(8'h3C);
    wr(8'hFF);
    stop_wr();
    drain();

    for (int i = 0; i < 10; i++) wr(8'(i));
    chk("fill_count", fifo_count, 4'd8);
    chk("fill_ready", tx_ready, 1'b0);
    tx_data = 8'h77;
    guard = 0;
    while (m_fifo.size() == DEPTH && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    tx_enable = 1'b0;
    chk("hold_count", fifo_count, 4'd7);
    drain();

    wr(8'h55);
    wr(8'h11);
    wr(8'h22);
    wr(8'h33);
    stop_wr();
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_tx", tx, 1'b1);
    chk("async_count", fifo_count, 4'd0);
    chk("async_ready", tx_ready, 1'b1);
    chk("async_busy", tx_busy, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("quiet_after_reset", tx_busy, 1'b0);

    idx = 0;
    guard = 0;
    while (idx < 20 && guard < 3000) begin
      @(negedge clk);
      guard++;
      if (m_ready) begin
        tx_enable = 1'b1;
        tx_data   = 8'h10 + 8'(idx);
        idx++;
      end else begin
        tx_enable = 1'b0;
      end
    end
    chk("wrap_all_written", idx, 20);
    stop_wr();
    drain();

    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      tx_enable = ($urandom_range(0, 3) == 0);
      tx_data   = 8'($urandom);
    end
    stop_wr();
    drain();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered 8N1 UART transmitter for sending MLP results and echo data off-chip. It accepts bytes over a valid/ready byte interface, queues them in a small FIFO, and serialises them onto the `tx` line at a fixed bit period. It is the outbound counterpart of the receive path in the serial front-end. Back-to-back queued bytes go out with no idle gap.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200). Must be ≥ 2.
- `FIFO_DEPTH`, default 8: byte FIFO depth. Must be a power of 2 and ≥ 2.
- `clk`  in  1  system clock; everything is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `tx_data`  in  8  byte to queue.
- `tx_enable`  in  1  write strobe. The byte is accepted on a rising edge where `tx_enable && tx_ready`.
- `tx_ready`  out  1  FIFO not full (registered).
- `tx`  out  1  serial line (registered). Idles high.
- `tx_busy`  out  1  high while a frame is on the line or the FIFO is non-empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0] for CLKS_PER_BIT cycles, then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. On the last stop cycle:
    - if the FIFO is non-empty, pop and go directly to START (no idle gap);
    - otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and is cleared on every state change.
- FIFO: circular buffer with pointer width $clog2(FIFO_DEPTH) and natural wrap-around.
  - `fifo_count` increments on push only, decrements on pop only, and is unchanged when both occur in the same cycle.
  - Push while full is ignored silently: data is dropped and the count is unchanged. This holds even if a pop occurs in the same cycle, because `tx_ready` is a registered flag.
  - Pop only happens when the FIFO is non-empty. A push into an empty FIFO cannot be popped in the same cycle.
- `tx_ready` is `fifo_count != FIFO_DEPTH`, registered from the next-state count.
- Reset (asynchronous, at any time, including mid-frame):
  - `tx`=1, `tx_ready`=1, `tx_busy`=0, `fifo_count`=0;
  - FSM returns to IDLE;
  - FIFO is flushed and any frame in progress is abandoned.
- No `tx` glitches: `tx` is driven from a flop only.

## Timing
- Accept-to-line latency: a byte accepted at edge N into an empty FIFO with an idle FSM is popped at edge N+1. `tx` falls after edge N+1.
- Frame length is exactly 10×CLKS_PER_BIT cycles.
- Back-to-back frames: the start bit of the next frame begins on the cycle immediately after the last stop cycle.
- `tx_busy` rises the cycle after the first accepted write. It falls after the last stop cycle when the FIFO is empty.
- `tx_ready` falls the cycle after the push that fills the FIFO. It rises the cycle after the next pop.

## Structure
- Shared package `serial_pkg` holds:
  - the state enum: IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11;
  - the constants `UART_DATA_BITS` = 8 and `UART_DEFAULT_CLKS_PER_BIT` = 434.
- Sub-module `byte_fifo`: parameterised FIFO with push/pop/full/empty/count. The top level holds the FSM, baud counter, bit index and shift register.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=8.
- Single byte 0xA5 -> `tx` shows 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles (40 cycles total). `tx` falls 2 edges after the write edge. `tx_busy` is high throughout the frame.
- Two writes, 0x3C then 0xFF, on consecutive cycles -> both frames are sent back-to-back: 80 cycles from the first start bit to the end of the second stop bit, with no high gap before the second start bit.
- Writes of 0x00..0x09 on 10 consecutive cycles:
  - 0x00 is popped after one cycle, so 0x01..0x08 fill the FIFO;
  - `fifo_count` reaches 8 and `tx_ready`=0;
  - 0x09 is dropped;
  - line output is 0x00..0x08 in order.
- Keep the FIFO full and hold `tx_enable`=1 with 0x77 during the pop cycle at the end of 0x00's frame -> 0x77 is not accepted because `tx_ready` was 0 at that edge. `fifo_count` goes from 8 to 7.
- Assert `reset` low mid-DATA of 0x55 with 3 bytes queued -> the checks below hold:
  - immediately (asynchronously) `tx`=1, `fifo_count`=0, `tx_ready`=1, `tx_busy`=0;
  - after release no frame is sent until a new write.
- FIFO wrap: stream 20 bytes 0x10..0x23, writing whenever `tx_ready`=1 -> all 20 bytes appear on the line in order with no loss or duplication.
